// File: rtl/faulty_row_allocator.sv
// faulty_row_allocator
//   Initiator side of the mapping-table update interface. Holds one
//   faulty-column pattern per physical PE row and derives faulty_rows_mask.
//   For each layer it takes one zero-weight mask per logical row, then emits
//   one single-cycle update pulse for that row. The pulse either places the
//   row on a compatible faulty row that is not yet allocated, reports that
//   no compatible row exists, or reports that every faulty row is taken.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   fault_wr_en/addr/data     fault pattern write (accepted in IDLE only)
//   start                     begin a layer (accepted in IDLE/DONE only)
//   row_valid/row_ready       zero-mask handshake, row_zero_mask payload
//   faulty_rows_mask          bit r set when physical row r has any fault
//   envm_wr_en                pulse after an accepted start
//   match_success/match_failed/all_faulty_matched  mutually exclusive pulses
//   faulty_addr               allocated faulty row (with match_success)
//   current_row_addr          logical row of the current update
//   done                      all rows issued, held until the next start
module faulty_row_allocator #(
  parameter int unsigned SYSTOLIC_SIZE = 8,
  parameter int unsigned ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fault_wr_en,
  input  logic [ADDR_WIDTH-1:0]    fault_wr_addr,
  input  logic [SYSTOLIC_SIZE-1:0] fault_wr_data,
  input  logic                     start,
  input  logic                     row_valid,
  output logic                     row_ready,
  input  logic [SYSTOLIC_SIZE-1:0] row_zero_mask,
  output logic [SYSTOLIC_SIZE-1:0] faulty_rows_mask,
  output logic                     envm_wr_en,
  output logic                     match_success,
  output logic                     match_failed,
  output logic                     all_faulty_matched,
  output logic [ADDR_WIDTH-1:0]    faulty_addr,
  output logic [ADDR_WIDTH-1:0]    current_row_addr,
  output logic                     done
);

  localparam int unsigned N = SYSTOLIC_SIZE;
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, MATCH, DONE} state_t;

  state_t                  state, state_n;
  logic [N-1:0]            fault_pattern [N];
  logic [N-1:0]            matched, matched_n;
  logic [N-1:0]            fmask_n;
  logic [ADDR_WIDTH-1:0]   row_cnt, row_cnt_n;
  logic                    row_ready_n, envm_n, succ_n, fail_n, afm_n, done_n;
  logic [ADDR_WIDTH-1:0]   fa_n, cra_n;

  logic                    wr_ok_c, start_ok_c, hs_c, last_c;
  logic [N-1:0]            avail_c;
  logic                    hit_c;
  logic [ADDR_WIDTH-1:0]   hit_addr_c;

  // Lowest-index unallocated faulty row whose faulty columns all carry zero weights
  always_comb begin
    avail_c    = faulty_rows_mask & ~matched;
    hit_c      = 1'b0;
    hit_addr_c = '0;
    for (int r = int'(N) - 1; r >= 0; r--) begin
      if (avail_c[r] && ((fault_pattern[r] & ~row_zero_mask) == '0)) begin
        hit_c      = 1'b1;
        hit_addr_c = ADDR_WIDTH'(r);
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    matched_n   = matched;
    fmask_n     = faulty_rows_mask;
    row_cnt_n   = row_cnt;
    envm_n      = 1'b0;
    succ_n      = 1'b0;
    fail_n      = 1'b0;
    afm_n       = 1'b0;
    fa_n        = '0;
    cra_n       = '0;
    done_n      = done;
    row_ready_n = 1'b0;

    wr_ok_c    = fault_wr_en && (state == IDLE);
    start_ok_c = start && ((state == IDLE) || (state == DONE));
    hs_c       = (state == RUN) && row_valid && row_ready;
    last_c     = (row_cnt == LAST_ROW);

    // A write accepted alongside a start lands before the mask is frozen
    if (wr_ok_c) fmask_n[fault_wr_addr] = |fault_wr_data;

    unique case (state)
      IDLE, DONE: begin
        if (start_ok_c) begin
          state_n   = RUN;
          matched_n = '0;
          row_cnt_n = '0;
          envm_n    = 1'b1;
          done_n    = 1'b0;
        end
      end
      RUN: begin
        if (hs_c) begin
          state_n = MATCH;
          cra_n   = row_cnt;
          if (avail_c == '0) begin
            afm_n = 1'b1;
          end else if (hit_c) begin
            succ_n                = 1'b1;
            fa_n                  = hit_addr_c;
            matched_n[hit_addr_c] = 1'b1;
          end else begin
            fail_n = 1'b1;
          end
        end
      end
      MATCH: begin
        if (last_c) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          state_n   = RUN;
          row_cnt_n = row_cnt + ADDR_WIDTH'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    row_ready_n = (state_n == RUN);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_pattern      <= '{default: '0};
      faulty_rows_mask   <= '0;
      matched            <= '0;
      row_cnt            <= '0;
      row_ready          <= 1'b0;
      envm_wr_en         <= 1'b0;
      match_success      <= 1'b0;
      match_failed       <= 1'b0;
      all_faulty_matched <= 1'b0;
      faulty_addr        <= '0;
      current_row_addr   <= '0;
      done               <= 1'b0;
    end else begin
      if (wr_ok_c) fault_pattern[fault_wr_addr] <= fault_wr_data;
      faulty_rows_mask   <= fmask_n;
      matched            <= matched_n;
      row_cnt            <= row_cnt_n;
      row_ready          <= row_ready_n;
      envm_wr_en         <= envm_n;
      match_success      <= succ_n;
      match_failed       <= fail_n;
      all_faulty_matched <= afm_n;
      faulty_addr        <= fa_n;
      current_row_addr   <= cra_n;
      done               <= done_n;
    end
  end

endmodule

// File: tb/tb_faulty_row_allocator.sv
// Self-checking bench for faulty_row_allocator: directed cases plus randomized
// layers, with a scoreboard of expected update pulses and envm pulses.
module tb_faulty_row_allocator;

  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          fault_wr_en;
  logic [AW-1:0] fault_wr_addr;
  logic [N-1:0]  fault_wr_data;
  logic          start;
  logic          row_valid;
  logic          row_ready;
  logic [N-1:0]  row_zero_mask;
  logic [N-1:0]  faulty_rows_mask;
  logic          envm_wr_en;
  logic          match_success;
  logic          match_failed;
  logic          all_faulty_matched;
  logic [AW-1:0] faulty_addr;
  logic [AW-1:0] current_row_addr;
  logic          done;

  faulty_row_allocator #(.SYSTOLIC_SIZE(N), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .fault_wr_en(fault_wr_en), .fault_wr_addr(fault_wr_addr), .fault_wr_data(fault_wr_data),
    .start(start), .row_valid(row_valid), .row_ready(row_ready), .row_zero_mask(row_zero_mask),
    .faulty_rows_mask(faulty_rows_mask), .envm_wr_en(envm_wr_en),
    .match_success(match_success), .match_failed(match_failed),
    .all_faulty_matched(all_faulty_matched), .faulty_addr(faulty_addr),
    .current_row_addr(current_row_addr), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 1 success, 2 failed, 3 all faulty matched
  typedef struct {
    int kind;
    int fa;
    int cra;
    int at;
  } exp_t;

  exp_t exp_q[$];
  int   envm_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [N-1:0] mpat [N];
  logic [N-1:0] mmatched;
  int           mrow;
  int           phase;   // 0 idle, 1 running, 2 done

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [N-1:0] model_mask();
    logic [N-1:0] m;
    for (int r = 0; r < N; r++) m[r] = (mpat[r] != '0);
    return m;
  endfunction

  function automatic exp_t predict(input logic [N-1:0] zm);
    exp_t e;
    bit   any_free;
    bit   found;
    e.cra = mrow;
    e.fa  = 0;
    e.at  = cyc + 1;
    any_free = 0;
    for (int r = 0; r < N; r++)
      if (mpat[r] != '0 && !mmatched[r]) any_free = 1;
    if (!any_free) begin
      e.kind = 3;
    end else begin
      found = 0;
      for (int r = 0; r < N; r++) begin
        if (!found && mpat[r] != '0 && !mmatched[r] && ((mpat[r] & ~zm) == '0)) begin
          found       = 1;
          e.fa        = r;
          mmatched[r] = 1'b1;
        end
      end
      e.kind = found ? 1 : 2;
    end
    mrow++;
    if (mrow == N) phase = 2;
    return e;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a pulse
  always @(negedge clk) begin
    int   kind;
    exp_t e;
    if (match_success || match_failed || all_faulty_matched) begin
      checks++;
      if (int'(match_success) + int'(match_failed) + int'(all_faulty_matched) > 1) begin
        errors++;
        $display("FAIL pulse_exclusive: s=%0b f=%0b a=%0b", match_success, match_failed, all_faulty_matched);
      end
      kind = match_success ? 1 : (match_failed ? 2 : 3);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_update: kind=%0d fa=%0d cra=%0d cycle=%0d", kind, faulty_addr, current_row_addr, cyc);
      end else begin
        e = exp_q.pop_front();
        if (kind != e.kind || int'(faulty_addr) != e.fa || int'(current_row_addr) != e.cra ||
            cyc != e.at || row_ready !== 1'b0) begin
          errors++;
          $display("FAIL update: got kind=%0d fa=%0d cra=%0d cycle=%0d ready=%0b expected kind=%0d fa=%0d cra=%0d cycle=%0d ready=0",
                   kind, faulty_addr, current_row_addr, cyc, row_ready, e.kind, e.fa, e.cra, e.at);
        end
      end
    end
    if (envm_wr_en) begin
      checks++;
      if (envm_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_envm: cycle=%0d", cyc);
      end else if (envm_q[0] != cyc) begin
        errors++;
        $display("FAIL envm_cycle: got %0d expected %0d", cyc, envm_q[0]);
        void'(envm_q.pop_front());
      end else begin
        void'(envm_q.pop_front());
      end
    end
  end

  // Called at a negedge; reset spans one posedge
  task automatic do_reset();
    rst = 1'b1;
    row_valid = 1'b0;
    start = 1'b0;
    fault_wr_en = 1'b0;
    @(negedge clk);
    chk("rst_pulses", {29'd0, match_success, match_failed, all_faulty_matched}, 32'd0);
    chk("rst_envm", 32'(envm_wr_en), 32'd0);
    chk("rst_ready", 32'(row_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mask", 32'(faulty_rows_mask), 32'd0);
    chk("rst_addrs", {26'd0, faulty_addr, current_row_addr}, 32'd0);
    rst = 1'b0;
    for (int r = 0; r < N; r++) mpat[r] = '0;
    mmatched = '0;
    mrow = 0;
    phase = 0;
  endtask

  task automatic write_pat(input int addr, input logic [N-1:0] data);
    @(negedge clk);
    fault_wr_en = 1'b1;
    fault_wr_addr = AW'(addr);
    fault_wr_data = data;
    if (phase == 0) mpat[addr] = data;
    @(negedge clk);
    fault_wr_en = 1'b0;
  endtask

  task automatic do_start(input bit wr, input int addr, input logic [N-1:0] data);
    @(negedge clk);
    start = 1'b1;
    if (wr) begin
      fault_wr_en = 1'b1;
      fault_wr_addr = AW'(addr);
      fault_wr_data = data;
      if (phase == 0) mpat[addr] = data;
    end
    if (phase != 1) begin
      envm_q.push_back(cyc + 1);
      mmatched = '0;
      mrow = 0;
      phase = 1;
    end
    @(negedge clk);
    start = 1'b0;
    fault_wr_en = 1'b0;
  endtask

  // Returns at the negedge inside the MATCH cycle, optionally after a gap
  task automatic send_row(input logic [N-1:0] zm, input int gap);
    int waited = 0;
    while (row_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (row_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake_timeout: row_ready=%0b expected 1", row_ready);
      return;
    end
    row_valid = 1'b1;
    row_zero_mask = zm;
    exp_q.push_back(predict(zm));
    @(negedge clk);
    row_valid = 1'b0;
    row_zero_mask = N'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_done();
    int waited = 0;
    while (done !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("done", 32'(done), 32'd1);
    chk("done_ready_low", 32'(row_ready), 32'd0);
    chk("done_mask", 32'(faulty_rows_mask), 32'(model_mask()));
  endtask

  function automatic logic [N-1:0] pick_mask();
    int k = $urandom_range(0, 3);
    logic [N-1:0] p;
    case (k)
      0: return N'($urandom);
      1: return '1;
      2: begin
        p = mpat[$urandom_range(0, N - 1)];
        return ~p & N'($urandom) | ~p;
      end
      default: return '0;
    endcase
  endfunction

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    fault_wr_en = 1'b0;
    fault_wr_addr = '0;
    fault_wr_data = '0;
    start = 1'b0;
    row_valid = 1'b0;
    row_zero_mask = '0;
    @(negedge clk);
    do_reset();

    // No faults: every row reports all faulty rows matched
    do_start(0, 0, '0);
    for (int i = 0; i < N; i++) send_row(N'($urandom), 0);
    wait_done();

    // Single faulty row 3 with column 2 faulty; gaps between rows
    do_reset();
    write_pat(3, 8'h04);
    chk("mask_row3", 32'(faulty_rows_mask), 32'h08);
    do_start(0, 0, '0);
    send_row(8'h00, 3);
    send_row(8'h04, 3);
    for (int i = 2; i < N; i++) send_row(N'($urandom), (i == 4) ? 3 : 0);
    wait_done();

    // Rows 2 and 5 share a pattern; the row-5 write rides with start
    do_reset();
    write_pat(2, 8'h01);
    do_start(1, 5, 8'h01);
    chk("mask_write_with_start", 32'(faulty_rows_mask), 32'h24);
    send_row(8'hFF, 0);
    send_row(8'h01, 0);
    for (int i = 2; i < N; i++) send_row(N'($urandom), 0);
    wait_done();

    // Reset in the middle of a run
    do_reset();
    write_pat(1, 8'h10);
    write_pat(6, 8'h81);
    do_start(0, 0, '0);
    for (int i = 0; i < 3; i++) send_row(N'($urandom), 0);
    do_reset();
    chk("post_rst_exp_empty", 32'(exp_q.size()), 32'd0);
    do_start(0, 0, '0);
    for (int i = 0; i < N; i++) send_row(N'($urandom), 0);
    wait_done();

    // Start and fault write during RUN are ignored
    do_reset();
    write_pat(0, 8'h02);
    write_pat(4, 8'h30);
    do_start(0, 0, '0);
    send_row(8'h32, 0);
    @(negedge clk);
    do_start(1, 7, 8'hFF);
    chk("mask_unchanged_in_run", 32'(faulty_rows_mask), 32'h11);
    for (int i = 1; i < N; i++) send_row(pick_mask(), 0);
    wait_done();

    // Randomized layers; odd layers restart from DONE with the same patterns
    for (int l = 0; l < 8; l++) begin
      if (l % 2 == 0) begin
        do_reset();
        for (int r = 0; r < N; r++)
          if ($urandom_range(0, 1) == 1)
            write_pat(r, N'(1 << $urandom_range(0, N - 1)) | N'(1 << $urandom_range(0, N - 1)));
      end
      do_start(0, 0, '0);
      for (int i = 0; i < N; i++) send_row(pick_mask(), $urandom_range(0, 2));
      wait_done();
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("envm_drained", 32'(envm_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
